avr_uart_rx: RTL and testbench

//  Testbench-side 8N1 UART receiver for the AVR TXD pin of the simulated core.
//  - Input is the pin net that avr_pin drives. Decodes the serial frames the firmware sends.
//  - Buffers received bytes in a small show-ahead FIFO.
//  - Flags framing errors and overruns so benches can check AVR serial output cycle-accurately.

---
 rtl/avr_uart_rx.sv | 175 +++++++++++++++++
 tb/tb_avr_uart_rx.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/avr_uart_rx.sv
// avr_uart_rx: 8N1 serial receiver for the AVR TXD pin in simulation.
// Decodes frames from the pin, buffers bytes in a show-ahead FIFO and
// raises single-cycle pulses on framing errors and FIFO overruns.
module avr_uart_rx #(
  parameter int CLKS_PER_BIT = 417,
  parameter int DEPTH        = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     rxd,
  input  logic                     rd_en,
  output logic [7:0]               rd_data,
  output logic                     rd_valid,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     frame_err,
  output logic                     overrun
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int AW    = $clog2(DEPTH);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [AW:0]      FULL_LVL  = (AW + 1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;

  logic             rx_sync_p0;
  logic             rx_sync_p1;
  logic             rxs;
  logic             rxd_clean;

  logic [7:0]       mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  logic             data_hit;
  logic             stop_hit;
  logic             push_req;
  logic             do_pop;
  logic             do_push;
  logic             full;

  // An undriven or unknown pin reads as the idle level.
  assign rxd_clean = (rxd !== 1'b0);
  assign rxs       = rx_sync_p1;

  // Stage p0 -> p1: two-flop synchronizer, reset to idle-high.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_sync_p0 <= 1'b1;
      rx_sync_p1 <= 1'b1;
    end else begin
      rx_sync_p0 <= rxd_clean;
      rx_sync_p1 <= rx_sync_p0;
    end
  end

  assign data_hit = (state == S_DATA) && (cnt == CNT_LAST);
  assign stop_hit = (state == S_STOP) && (cnt == CNT_LAST);
  assign push_req = stop_hit && rxs;

  // Frame FSM: start qualification at half bit, then whole-bit sampling.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!rxs) begin
            state <= S_START;
            cnt   <= '0;
          end
        end
        S_START: begin
          if (cnt == HALF_LAST) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= rxs ? S_IDLE : S_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (cnt == CNT_LAST) begin
            cnt <= '0;
            if (bit_idx == 3'd7) begin
              state <= S_STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            state <= rxs ? S_IDLE : S_BREAK;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_BREAK: begin
          if (rxs) begin
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Data shift register, LSB arrives first so it shifts in from the top.
  always_ff @(posedge clk) begin
    if (data_hit) begin
      shreg <= {rxs, shreg[7:1]};
    end
  end

  assign full     = (level == FULL_LVL);
  assign rd_valid = (level != '0);
  assign do_pop   = rd_en && rd_valid;
  assign do_push  = push_req && (!full || do_pop);
  assign rd_data  = rd_valid ? mem[rd_ptr] : 8'h00;

  // FIFO storage; when full with a simultaneous pop, the slot written is the one being vacated.
  always_ff @(posedge clk) begin
    if (do_push && !reset) begin
      mem[wr_ptr] <= shreg;
    end
  end

  // FIFO pointers, occupancy and the error pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= stop_hit && !rxs;
      overrun   <= push_req && full && !do_pop;
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: tb/tb_avr_uart_rx.sv
// tb_avr_uart_rx: directed frames against avr_uart_rx at 16 clocks per bit.
module tb_avr_uart_rx;

  localparam int CPB   = 16;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rxd_drv = 1'b1;
  logic       rxd_oe = 1'b1;
  logic       rd_en = 1'b0;
  wire        rxd_w;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic [2:0] level;
  logic       frame_err;
  logic       overrun;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int lat    = -1;
  int c0     = 0;
  int fe0    = 0;
  int ov0    = 0;

  // Pin model: released driver floats, pull-up keeps the line idle.
  assign rxd_w = rxd_oe ? rxd_drv : 1'bz;
  pullup (rxd_w);

  avr_uart_rx #(
    .CLKS_PER_BIT(CPB),
    .DEPTH       (DEPTH)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rxd      (rxd_w),
    .rd_en    (rd_en),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .level    (level),
    .frame_err(frame_err),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (frame_err) fe_cnt <= fe_cnt + 1;
    if (overrun)   ov_cnt <= ov_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    rxd_drv = b;
    wait_clk(CPB);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop);
    rxd_drv = 1'b1;
  endtask

  task automatic pop_check(input string tag, input logic [7:0] exp);
    check(tag, {24'h0, rd_data}, {24'h0, exp});
    rd_en = 1'b1;
    wait_clk(1);
    rd_en = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    wait_clk(3);
    check("rst rd_valid", {31'h0, rd_valid}, 32'h0);
    check("rst level", {29'h0, level}, 32'h0);
    check("rst rd_data", {24'h0, rd_data}, 32'h0);
    reset = 1'b0;
    wait_clk(2);
    check("idle frame_err", {31'h0, frame_err}, 32'h0);
    check("idle overrun", {31'h0, overrun}, 32'h0);

    // 1: latency and contents of a single frame
    c0 = cyc;
    fork
      send_frame(8'hA5, 1'b1);
      begin
        for (int i = 0; i < 400; i++) begin
          @(negedge clk);
          if (rd_valid) begin
            lat = cyc - c0;
            break;
          end
        end
      end
    join
    check("t1 latency", lat, 32'd155);
    check("t1 level", {29'h0, level}, 32'd1);
    pop_check("t1 data", 8'hA5);
    check("t1 empty", {29'h0, level}, 32'd0);

    // 2: short low glitch is rejected, next frame still decodes
    fe0 = fe_cnt;
    rxd_drv = 1'b0;
    wait_clk(4);
    rxd_drv = 1'b1;
    wait_clk(40);
    check("t2 level", {29'h0, level}, 32'd0);
    check("t2 frame_err", fe_cnt - fe0, 32'd0);
    send_frame(8'h5A, 1'b1);
    wait_clk(4);
    check("t2 level after", {29'h0, level}, 32'd1);
    pop_check("t2 data", 8'h5A);

    // 3: framing error, held break, then recovery
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    send_frame(8'h3C, 1'b0);
    rxd_drv = 1'b0;
    wait_clk(50);
    check("t3 frame_err", fe_cnt - fe0, 32'd1);
    check("t3 level", {29'h0, level}, 32'd0);
    rxd_drv = 1'b1;
    wait_clk(32);
    send_frame(8'h01, 1'b1);
    wait_clk(4);
    check("t3 frame_err after", fe_cnt - fe0, 32'd1);
    check("t3 level after", {29'h0, level}, 32'd1);
    pop_check("t3 data", 8'h01);

    // 4: overrun on the fifth unread frame
    ov0 = ov_cnt;
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1);
    wait_clk(4);
    check("t4 level", {29'h0, level}, 32'd4);
    check("t4 overrun", ov_cnt - ov0, 32'd1);
    pop_check("t4 rd0", 8'h01);
    pop_check("t4 rd1", 8'h02);
    pop_check("t4 rd2", 8'h03);
    pop_check("t4 rd3", 8'h04);
    check("t4 empty", {29'h0, rd_valid}, 32'd0);

    // 5: push and pop on the same cycle while full
    for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1);
    ov0 = ov_cnt;
    fork
      send_frame(8'h05, 1'b1);
      begin
        repeat (154) @(posedge clk);
        #1;
        check("t5 level pre", {29'h0, level}, 32'd4);
        check("t5 head pre", {24'h0, rd_data}, 32'h01);
        rd_en = 1'b1;
        wait_clk(1);
        rd_en = 1'b0;
        check("t5 level post", {29'h0, level}, 32'd4);
      end
    join
    wait_clk(4);
    check("t5 overrun", ov_cnt - ov0, 32'd0);
    pop_check("t5 rd0", 8'h02);
    pop_check("t5 rd1", 8'h03);
    pop_check("t5 rd2", 8'h04);
    pop_check("t5 rd3", 8'h05);

    // 6: reset mid-frame with a byte buffered
    send_frame(8'h33, 1'b1);
    wait_clk(4);
    check("t6 level pre", {29'h0, level}, 32'd1);
    fe0 = fe_cnt;
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    rxd_drv = 1'b0;
    wait_clk(6);
    reset = 1'b1;
    rxd_drv = 1'b1;
    wait_clk(2);
    reset = 1'b0;
    check("t6 rst level", {29'h0, level}, 32'd0);
    check("t6 rst rd_valid", {31'h0, rd_valid}, 32'd0);
    check("t6 rst rd_data", {24'h0, rd_data}, 32'h0);
    wait_clk(32);
    check("t6 no partial", {29'h0, level}, 32'd0);
    send_frame(8'h7E, 1'b1);
    wait_clk(4);
    check("t6 level", {29'h0, level}, 32'd1);
    pop_check("t6 data", 8'h7E);
    check("t6 frame_err", fe_cnt - fe0, 32'd0);

    // 6b: floating line reads as idle
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    rxd_oe = 1'b0;
    wait_clk(1000);
    check("t6z level", {29'h0, level}, 32'd0);
    check("t6z frame_err", fe_cnt - fe0, 32'd0);
    check("t6z overrun", ov_cnt - ov0, 32'd0);
    rxd_drv = 1'b1;
    rxd_oe = 1'b1;
    wait_clk(8);
    send_frame(8'hC3, 1'b1);
    wait_clk(4);
    pop_check("t6z data", 8'hC3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
